sram22_req_adapter: RTL and testbench
=====================================

// Module: sram22_req_adapter
// PURPOSE
//  Valid/ready front end for one sram22_512x32m8w4 macro. Accepts byte-strobed read/write
//  requests, drives the macro's synchronous pins, captures read data one cycle after the
//  access and queues it in a small response FIFO. Read data is never lost under back-pressure.
//  Sits between the bus/core and the SRAM macro; it is the macro's only driver.
// PARAMETERS
//  DATA_WIDTH   32  data word width; must equal macro DATA_WIDTH
//  ADDR_WIDTH   9   word address width; must equal macro ADDR_WIDTH
//  STRB_WIDTH   4   byte strobes, DATA_WIDTH/8
//  WMASK_WIDTH  8   macro nibble-mask width, DATA_WIDTH/4
//  RSP_DEPTH    3   response FIFO entries; must be >=2; 3 gives one read per cycle at full rate
// PORTS
//  clk         in   1            clock; also clocks the macro
//  rst_n       in   1            asynchronous reset, active low
//  req_valid   in   1            request present
//  req_ready   out  1            request accepted when req_valid && req_ready
//  req_we      in   1            1 = write, 0 = read
//  req_addr    in   ADDR_WIDTH   word address
//  req_wdata   in   DATA_WIDTH   write data
//  req_strb    in   STRB_WIDTH   byte write enables; ignored on reads
//  rsp_valid   out  1            read data available
//  rsp_ready   in   1            consumer takes rsp_rdata when rsp_valid && rsp_ready
//  rsp_rdata   out  DATA_WIDTH   read data, in request order
//  sram_we     out  1            to macro we
//  sram_wmask  out  WMASK_WIDTH  to macro wmask
//  sram_addr   out  ADDR_WIDTH   to macro addr
//  sram_din    out  DATA_WIDTH   to macro din
//  sram_dout   in   DATA_WIDTH   from macro dout
// BEHAVIOUR
//  - Reset (async assert, sync release): FIFO empty, rd_inflight=0, rsp_valid=0, req_ready=0
//    while rst_n=0, rsp_rdata=0. Macro contents are untouched by reset.
//  - req_ready = rst_n && (fifo_count + rd_inflight < RSP_DEPTH); registered state only,
//    no combinational path from rsp_ready or req_valid.
//  - Macro pins combinational from the request: sram_addr=req_addr, sram_din=req_wdata,
//    sram_we = req_valid && req_ready && req_we. sram_wmask[2i+1:2i] = {2{req_strb[i]}}
//    when sram_we, else 0. Idle cycles are harmless dummy reads.
//  - Write: committed at the accepting edge; no response generated. strb=0 is a legal no-op write.
//  - Read accepted at edge N: rd_inflight=1 for cycle N+1; sram_dout pushed into FIFO at
//    edge N+1; rsp_valid high from cycle N+2 at the earliest (2-cycle latency, empty FIFO).
//  - sram_dout is sampled only when rd_inflight=1; X data after writes never enters the FIFO.
//  - Push and pop in the same cycle are both honoured; count unchanged. Credit check
//    guarantees no push into a full FIFO; overflow is a design error (assertion).
//  - Read after write to same address in the next request returns the new data (macro semantics).
//  - Reset mid-operation: in-flight read and queued responses are discarded; rsp_valid drops
//    asynchronously with rst_n.
// STRUCTURE
//  - sram22_pkg: width localparams, strb_to_nibble_mask() function.
//  - Sub-module sram22_rsp_fifo: synchronous FIFO, DEPTH/WIDTH params, count output,
//    async active-low reset, no read-during-empty bypass.
//  - Top holds rd_inflight flop, credit compare, mask expansion.
// TESTING
//  1. Hold rst_n=0 10 cycles -> req_ready=0, rsp_valid=0, sram_we=0; release -> req_ready=1.
//  2. Write 0x005 <- 0xDEADBEEF strb 4'hF (sram_wmask=8'hFF); read 0x005 -> rsp_rdata
//     0xDEADBEEF, rsp_valid exactly 2 cycles after read accept.
//  3. Write 0x005 <- 0x0000AB00 strb 4'b0010 -> sram_wmask=8'h0C; read -> 0xDEADABEF.
//  4. 8 back-to-back reads 0x000..0x007 with rsp_ready=1 -> 8 responses, one per cycle, in order.
//  5. Same 8 reads with rsp_ready=0 -> req_ready falls after 3 accepts; raise rsp_ready ->
//     all 8 returned in order, none lost or duplicated.
//  6. Reads of 0x000 and 0x1FF queued, assert rst_n=0 mid-flight -> rsp_valid=0 at once;
//     after release no stale response appears; data at 0x1FF retained on re-read.

Source files
------------

// File: rtl/sram22_pkg.sv
// Shared widths and helpers for the sram22_512x32m8w4 request adapter.
// The macro masks writes per nibble, so each byte strobe drives two mask bits.
package sram22_pkg;

  localparam int SRAM_DATA_W  = 32;
  localparam int SRAM_ADDR_W  = 9;
  localparam int SRAM_STRB_W  = SRAM_DATA_W / 8;
  localparam int SRAM_WMASK_W = SRAM_DATA_W / 4;
  localparam int SRAM_RSP_DEPTH = 3;

  function automatic logic [SRAM_WMASK_W-1:0] strb_to_nibble_mask(
    input logic [SRAM_STRB_W-1:0] strb
  );
    logic [SRAM_WMASK_W-1:0] mask;
    mask = '0;
    for (int i = 0; i < SRAM_STRB_W; i++) begin
      mask[2*i +: 2] = {2{strb[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/sram22_rsp_fifo.sv
// Small synchronous response FIFO with an occupancy count.
// Output reads as zero while empty; there is no bypass from push to the output.
module sram22_rsp_fifo
  import sram22_pkg::*;
#(
  parameter int DEPTH = SRAM_RSP_DEPTH,
  parameter int WIDTH = SRAM_DATA_W,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty, full, do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i && !empty;
  assign do_push = push_i && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage has no reset; emptiness is tracked solely by count_q.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = empty ? '0 : mem_q[rd_ptr_q];
  assign valid_o = !empty;
  assign count_o = count_q;

  overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && full && !pop_i));

endmodule

// File: rtl/sram22_req_adapter.sv
// Valid/ready front end for one sram22_512x32m8w4 macro: drives the macro pins from
// the accepted request and queues read data so responses survive back-pressure.
module sram22_req_adapter
  import sram22_pkg::*;
#(
  parameter int DATA_WIDTH  = SRAM_DATA_W,
  parameter int ADDR_WIDTH  = SRAM_ADDR_W,
  parameter int STRB_WIDTH  = SRAM_STRB_W,
  parameter int WMASK_WIDTH = SRAM_WMASK_W,
  parameter int RSP_DEPTH   = SRAM_RSP_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0]  req_wdata,
  input  logic [STRB_WIDTH-1:0]  req_strb,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_WIDTH-1:0]  rsp_rdata,
  output logic                   sram_we,
  output logic [WMASK_WIDTH-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0]  sram_din,
  input  logic [DATA_WIDTH-1:0]  sram_dout
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  logic             rd_inflight_q, rd_inflight_d;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] credit_used;
  logic             credit_ok;
  logic             accept;

  // A read in flight already owns a FIFO slot, so it counts against the credit.
  assign credit_used = fifo_count + CNT_W'(rd_inflight_q);
  assign credit_ok   = (credit_used < CNT_W'(RSP_DEPTH));
  assign req_ready   = rst_n && credit_ok;
  assign accept      = req_valid && req_ready;

  assign sram_addr  = req_addr;
  assign sram_din   = req_wdata;
  assign sram_we    = accept && req_we;
  assign sram_wmask = sram_we ? WMASK_WIDTH'(strb_to_nibble_mask(SRAM_STRB_W'(req_strb))) : '0;

  assign rd_inflight_d = accept && !req_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_inflight_q <= 1'b0;
    else        rd_inflight_q <= rd_inflight_d;
  end

  sram22_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_WIDTH),
    .CNT_W (CNT_W)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rd_inflight_q),
    .wdata_i (sram_dout),
    .pop_i   (rsp_ready),
    .rdata_o (rsp_rdata),
    .valid_o (rsp_valid),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_sram22_req_adapter.sv
// Directed bench for sram22_req_adapter with a behavioural model of the nibble-masked macro.
module tb_sram22_req_adapter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_strb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        sram_we;
  logic [7:0]  sram_wmask;
  logic [8:0]  sram_addr;
  logic [31:0] sram_din;
  logic [31:0] sram_dout;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int req_cyc;
  logic [31:0] rx_q [$];
  int          rx_cyc_q [$];

  sram22_req_adapter dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .sram_we(sram_we), .sram_wmask(sram_wmask), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Macro model: synchronous nibble-masked write, registered read, X on write cycles.
  logic [31:0] mem_m [0:511];
  always @(posedge clk) begin
    if (sram_we) begin
      for (int j = 0; j < 8; j++)
        if (sram_wmask[j]) mem_m[sram_addr][4*j +: 4] <= sram_din[4*j +: 4];
    end
    sram_dout <= sram_we ? 32'hxxxx_xxxx : mem_m[sram_addr];
  end

  // Response monitor; inputs change just after posedge so negedge sampling is race-free.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      rx_q.push_back(rsp_rdata);
      rx_cyc_q.push_back(cyc);
      $display("rsp data=%h cycle=%0d", rsp_rdata, cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic we, input logic [8:0] addr, input logic [31:0] data,
                      input logic [3:0] strb);
    int k = 0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data; req_strb = strb;
    while (!req_ready && k < 100) begin
      @(posedge clk); #1; k++;
    end
    if (k == 100) chk("send_timeout", 32'(req_ready), 32'd1);
    req_cyc = cyc;
    $display("req we=%0d addr=%h wdata=%h strb=%h cycle=%0d", we, addr, data, strb, cyc);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  task automatic wait_rx(input string tag, input int n);
    int k = 0;
    while (rx_q.size() < n && k < 60) begin
      @(posedge clk); #1; k++;
    end
    chk(tag, 32'(rx_q.size()), 32'(n));
  endtask

  function automatic logic [31:0] pat(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h0011_0101;
  endfunction

  initial begin
    int acc;
    rst_n = 1'b0; rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 9'h000; req_wdata = 32'h0; req_strb = 4'hF;

    // 1. reset
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_sram_we",   32'(sram_we),   32'd0);
    chk("rst_rsp_rdata", rsp_rdata,      32'd0);
    idle();
    rst_n = 1'b1;
    #1 chk("rel_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;

    // 2. full write, read with latency check
    req_valid = 1'b1; req_we = 1'b1; req_addr = 9'h005; req_wdata = 32'hDEADBEEF; req_strb = 4'hF;
    #1 chk("t2_wmask", 32'(sram_wmask), 32'h0000_00FF);
    chk("t2_sram_we", 32'(sram_we), 32'd1);
    send(1'b1, 9'h005, 32'hDEADBEEF, 4'hF);
    idle();
    @(posedge clk); #1;
    rx_q.delete(); rx_cyc_q.delete();
    send(1'b0, 9'h005, 32'h0, 4'h0);
    idle();
    wait_rx("t2_rx_count", 1);
    if (rx_q.size() >= 1) begin
      chk("t2_rdata", rx_q[0], 32'hDEADBEEF);
      chk("t2_latency", 32'(rx_cyc_q[0] - req_cyc), 32'd2);
    end

    // 3. byte-1 write followed immediately by read-back
    rx_q.delete(); rx_cyc_q.delete();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 9'h005; req_wdata = 32'h0000AB00; req_strb = 4'b0010;
    #1 chk("t3_wmask", 32'(sram_wmask), 32'h0000_000C);
    send(1'b1, 9'h005, 32'h0000AB00, 4'b0010);
    send(1'b0, 9'h005, 32'h0, 4'h0);
    idle();
    wait_rx("t3_rx_count", 1);
    if (rx_q.size() >= 1) chk("t3_rdata", rx_q[0], 32'hDEADABEF);

    // preload 0..7 and 0x1FF
    for (int i = 0; i < 8; i++) send(1'b1, 9'(i), pat(i), 4'hF);
    send(1'b1, 9'h1FF, 32'hCAFEF00D, 4'hF);
    idle();
    @(posedge clk); #1;

    // 4. eight back-to-back reads, consumer always ready
    rx_q.delete(); rx_cyc_q.delete();
    for (int i = 0; i < 8; i++) send(1'b0, 9'(i), 32'h0, 4'h0);
    idle();
    wait_rx("t4_rx_count", 8);
    if (rx_q.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("t4_data%0d", i), rx_q[i], pat(i));
        if (i > 0) chk($sformatf("t4_gap%0d", i), 32'(rx_cyc_q[i] - rx_cyc_q[i-1]), 32'd1);
      end
    end

    // 5. same reads under back-pressure
    rx_q.delete(); rx_cyc_q.delete();
    rsp_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = 9'(acc);
      if (req_ready) acc++;
      @(posedge clk); #1;
    end
    idle();
    chk("t5_accepts", 32'(acc), 32'd3);
    chk("t5_ready_low", 32'(req_ready), 32'd0);
    chk("t5_no_rx", 32'(rx_q.size()), 32'd0);
    rsp_ready = 1'b1;
    for (int i = 3; i < 8; i++) send(1'b0, 9'(i), 32'h0, 4'h0);
    idle();
    wait_rx("t5_rx_count", 8);
    repeat (4) @(posedge clk);
    #1 chk("t5_no_dup", 32'(rx_q.size()), 32'd8);
    if (rx_q.size() == 8)
      for (int i = 0; i < 8; i++) chk($sformatf("t5_data%0d", i), rx_q[i], pat(i));

    // 6. reset with responses queued and a read in flight
    rx_q.delete(); rx_cyc_q.delete();
    rsp_ready = 1'b0;
    send(1'b0, 9'h000, 32'h0, 4'h0);
    send(1'b0, 9'h1FF, 32'h0, 4'h0);
    idle();
    chk("t6_pre_valid", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1 chk("t6_async_valid", 32'(rsp_valid), 32'd0);
    chk("t6_async_ready", 32'(req_ready), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    repeat (6) @(posedge clk);
    #1 chk("t6_no_stale", 32'(rx_q.size()), 32'd0);
    send(1'b0, 9'h1FF, 32'h0, 4'h0);
    idle();
    wait_rx("t6_rx_count", 1);
    if (rx_q.size() >= 1) chk("t6_retained", rx_q[0], 32'hCAFEF00D);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
